// File: rtl/hs_pkg.sv
// Shared definitions for the round-robin handshake FIFO.
// Default geometry, the stored-entry layout for that geometry and the
// round-robin successor function used by the arbiter.
package hs_pkg;

    localparam int HS_DW    = 8;
    localparam int HS_NCH   = 4;
    localparam int HS_DEPTH = 4;

    // Stored word layout {channel tag, data} for the default geometry.
    typedef struct packed {
        logic [$clog2(HS_NCH)-1:0] ch;
        logic [HS_DW-1:0]          data;
    } hs_entry_t;

    // Index that follows idx in a ring of n channels.
    function automatic int rr_next(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/hs_rr_arb.sv
// Round-robin arbiter: grants the first request at or after rr_ptr,
// wrapping, and moves rr_ptr past the winner only when the grant is used.
module hs_rr_arb
    import hs_pkg::*;
#(
    parameter int NCH = HS_NCH,
    localparam int CHW = $clog2(NCH)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [NCH-1:0] req,
    input  logic           accept,
    output logic [NCH-1:0] grant,
    output logic [CHW-1:0] grant_idx,
    output logic           grant_valid
);

    logic [CHW-1:0] rr_ptr;

    // Priority search starting at rr_ptr; first asserted request wins.
    always_comb begin
        int             idx;
        logic [CHW-1:0] sel;
        grant       = '0;
        grant_idx   = '0;
        grant_valid = 1'b0;
        idx         = 0;
        sel         = '0;
        for (int off = 0; off < NCH; off++) begin
            idx = int'(rr_ptr) + off;
            if (idx >= NCH) begin
                idx = idx - NCH;
            end
            sel = CHW'(idx);
            if (!grant_valid && req[sel]) begin
                grant_valid = 1'b1;
                grant[sel]  = 1'b1;
                grant_idx   = sel;
            end
        end
    end

    // Pointer advances past the channel that actually transferred.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rr_ptr <= '0;
        end else if (accept) begin
            rr_ptr <= CHW'(rr_next(int'(grant_idx), NCH));
        end
    end

endmodule

// File: rtl/hs_rr_fifo.sv
// Multi-channel send/ready merge into a DEPTH-entry FIFO with a
// valid/load drain. Each stored word carries its source channel tag.
// Optional build macro HS_RR_FIFO_PARITY_EN adds output bpar: even parity
// of {dch, dout}, computed and stored at write time.
module hs_rr_fifo
    import hs_pkg::*;
#(
    parameter int DW    = HS_DW,
    parameter int NCH   = HS_NCH,
    parameter int DEPTH = HS_DEPTH,
    localparam int CHW  = $clog2(NCH),
    localparam int LW   = $clog2(DEPTH) + 1
) (
    input  logic              aclk,
    input  logic              arst_n,
    input  logic [NCH*DW-1:0] adata,
    input  logic [NCH-1:0]    asend,
    output logic [NCH-1:0]    aready,
    input  logic              bload,
    output logic              bvalid,
    output logic [DW-1:0]     dout,
    output logic [CHW-1:0]    dch,
`ifdef HS_RR_FIFO_PARITY_EN
    output logic              bpar,
`endif
    output logic [LW-1:0]     level
);

    localparam int AW = $clog2(DEPTH);

    typedef struct packed {
`ifdef HS_RR_FIFO_PARITY_EN
        logic           par;
`endif
        logic [CHW-1:0] ch;
        logic [DW-1:0]  data;
    } entry_t;

    entry_t         mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic [AW-1:0]  rd_nxt;
    logic [LW-1:0]  level_q;
    logic [LW-1:0]  level_nxt;
    logic           bvalid_q;
    entry_t         head_q;
    entry_t         head_nxt;
    entry_t         wr_entry;
    logic           full;
    logic           wr_en;
    logic           rd_en;
    logic [NCH-1:0] grant;
    logic [CHW-1:0] grant_idx;
    logic           grant_valid;

    hs_rr_arb #(
        .NCH(NCH)
    ) u_arb (
        .clk        (aclk),
        .rst_n      (arst_n),
        .req        (asend),
        .accept     (wr_en),
        .grant      (grant),
        .grant_idx  (grant_idx),
        .grant_valid(grant_valid)
    );

    assign full   = (level_q == LW'(DEPTH));
    assign aready = grant & {NCH{~full & arst_n}};
    assign wr_en  = grant_valid & ~full & arst_n;
    assign rd_en  = bvalid_q & bload;
    assign rd_nxt = rd_ptr + AW'(1);

    // Entry built from the granted channel's data and tag.
    always_comb begin
        wr_entry      = '0;
        wr_entry.ch   = grant_idx;
        wr_entry.data = adata[grant_idx*DW +: DW];
`ifdef HS_RR_FIFO_PARITY_EN
        wr_entry.par  = ^{grant_idx, adata[grant_idx*DW +: DW]};
`endif
    end

    // Fill level after this cycle's write/read combination.
    always_comb begin
        level_nxt = level_q;
        case ({wr_en, rd_en})
            2'b10:   level_nxt = level_q + LW'(1);
            2'b01:   level_nxt = level_q - LW'(1);
            default: level_nxt = level_q;
        endcase
    end

    // Next head: successor after a load (taken from the incoming word if it
    // is the only one left), the incoming word when empty, else hold.
    always_comb begin
        head_nxt = head_q;
        if (rd_en) begin
            if (level_q > LW'(1)) begin
                head_nxt = mem[rd_nxt];
            end else if (wr_en) begin
                head_nxt = wr_entry;
            end
        end else if (wr_en && level_q == '0) begin
            head_nxt = wr_entry;
        end
    end

    // Storage, pointers, level and registered head outputs.
    always_ff @(posedge aclk) begin
        if (!arst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level_q  <= '0;
            bvalid_q <= 1'b0;
            head_q   <= '0;
        end else begin
            if (wr_en) begin
                mem[wr_ptr] <= wr_entry;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (rd_en) begin
                rd_ptr <= rd_nxt;
            end
            level_q  <= level_nxt;
            bvalid_q <= (level_nxt != '0);
            head_q   <= head_nxt;
        end
    end

    assign bvalid = bvalid_q;
    assign level  = level_q;
    assign dout   = head_q.data;
    assign dch    = head_q.ch;
`ifdef HS_RR_FIFO_PARITY_EN
    assign bpar   = head_q.par;
`endif

endmodule

// File: tb/tb_hs_rr_fifo.sv
// Scoreboard bench for hs_rr_fifo: accepted words are queued with their
// channel and checked in order as they are loaded out.
module tb_hs_rr_fifo;

    localparam int DW    = 8;
    localparam int NCH   = 4;
    localparam int DEPTH = 4;
    localparam int CHW   = $clog2(NCH);
    localparam int LW    = $clog2(DEPTH) + 1;

    logic              aclk;
    logic              arst_n;
    logic [NCH*DW-1:0] adata;
    logic [NCH-1:0]    asend;
    logic [NCH-1:0]    aready;
    logic              bload;
    logic              bvalid;
    logic [DW-1:0]     dout;
    logic [CHW-1:0]    dch;
    logic [LW-1:0]     level;
`ifdef HS_RR_FIFO_PARITY_EN
    logic              bpar;
`endif

    int checks = 0;
    int errors = 0;

    logic [CHW+DW-1:0] m_q [$];
    int                got_ch [$];
    int                m_level = 0;
    int                m_rr    = 0;

    hs_rr_fifo #(
        .DW(DW),
        .NCH(NCH),
        .DEPTH(DEPTH)
    ) dut (
        .aclk  (aclk),
        .arst_n(arst_n),
        .adata (adata),
        .asend (asend),
        .aready(aready),
        .bload (bload),
        .bvalid(bvalid),
        .dout  (dout),
        .dch   (dch),
`ifdef HS_RR_FIFO_PARITY_EN
        .bpar  (bpar),
`endif
        .level (level)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    // One clock: check arbitration and outputs against the model at the
    // falling edge, update the model, then step past the rising edge.
    task automatic tick();
        logic [NCH-1:0]    exp_rdy;
        logic [CHW+DW-1:0] exp_w;
        int                k;
        int                c;
        logic              rd;
        @(negedge aclk);
        exp_rdy = '0;
        k       = -1;
        if (arst_n && m_level < DEPTH) begin
            for (int off = 0; off < NCH; off++) begin
                c = (m_rr + off) % NCH;
                if (k < 0 && asend[c]) k = c;
            end
        end
        if (k >= 0) exp_rdy[k] = 1'b1;
        checks++;
        if (aready !== exp_rdy) begin
            errors++;
            $display("FAIL aready: got %b expected %b", aready, exp_rdy);
        end
        checks++;
        if (bvalid !== (m_level != 0)) begin
            errors++;
            $display("FAIL bvalid: got %b expected %0d", bvalid, m_level != 0);
        end
        checks++;
        if (level !== LW'(m_level)) begin
            errors++;
            $display("FAIL level: got %0d expected %0d", level, m_level);
        end
        rd = arst_n && (m_level != 0) && bload;
        if (rd) begin
            exp_w = m_q.pop_front();
            got_ch.push_back(int'(dch));
            checks++;
            if ({dch, dout} !== exp_w) begin
                errors++;
                $display("FAIL word: got ch%0d %h expected ch%0d %h",
                         dch, dout, exp_w[CHW+DW-1:DW], exp_w[DW-1:0]);
            end
`ifdef HS_RR_FIFO_PARITY_EN
            checks++;
            if (bpar !== ^exp_w) begin
                errors++;
                $display("FAIL bpar: got %b expected %b", bpar, ^exp_w);
            end
`endif
        end
        if (k >= 0) begin
            m_q.push_back({CHW'(k), adata[k*DW +: DW]});
            m_rr = (k + 1) % NCH;
        end
        m_level = m_level + ((k >= 0) ? 1 : 0) - (rd ? 1 : 0);
        if (!arst_n) begin
            m_q.delete();
            m_level = 0;
            m_rr    = 0;
        end
        @(posedge aclk);
        #1;
    endtask

    task automatic drain();
        asend = '0;
        bload = 1'b1;
        for (int i = 0; i < 20 && m_level != 0; i++) tick();
        checks++;
        if (m_level != 0 || level !== '0) begin
            errors++;
            $display("FAIL drain: level %0d expected 0", level);
        end
        bload = 1'b0;
    endtask

    task automatic test_reset();
        arst_n = 1'b0;
        asend  = 4'b1111;
        adata  = 32'h44332211;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (dout !== '0 || dch !== '0) begin
                errors++;
                $display("FAIL reset_head: got ch%0d %h expected ch0 00", dch, dout);
            end
        end
        asend  = '0;
        arst_n = 1'b1;
        tick();
    endtask

    task automatic test_single();
        asend = 4'b0100;
        adata = '0;
        adata[2*DW +: DW] = 8'hA5;
        bload = 1'b1;
        tick();
        checks++;
        if (bvalid !== 1'b1 || dout !== 8'hA5 || dch !== 2'd2) begin
            errors++;
            $display("FAIL single: got v%b ch%0d %h expected v1 ch2 a5", bvalid, dch, dout);
        end
        asend = '0;
        tick();
        tick();
        checks++;
        if (level !== '0) begin
            errors++;
            $display("FAIL single_level: got %0d expected 0", level);
        end
        bload = 1'b0;
    endtask

    task automatic test_round_robin();
        arst_n = 1'b0;
        tick();
        arst_n = 1'b1;
        got_ch.delete();
        asend = 4'b1111;
        bload = 1'b1;
        for (int i = 0; i < 12; i++) begin
            for (int c = 0; c < NCH; c++) adata[c*DW +: DW] = DW'((c << 4) | i);
            tick();
            checks++;
            if ($countones(aready) > 1) begin
                errors++;
                $display("FAIL onehot: got %b expected at most one bit", aready);
            end
        end
        drain();
        checks++;
        if (got_ch.size() != 12) begin
            errors++;
            $display("FAIL rr_count: got %0d expected 12", got_ch.size());
        end
        foreach (got_ch[i]) begin
            checks++;
            if (got_ch[i] != i % NCH) begin
                errors++;
                $display("FAIL rr_order[%0d]: got %0d expected %0d", i, got_ch[i], i % NCH);
            end
        end
    endtask

    task automatic test_full();
        bload = 1'b0;
        asend = 4'b0001;
        for (int i = 0; i < 6; i++) begin
            adata[DW-1:0] = DW'(8'h10 + i);
            tick();
        end
        checks++;
        if (level !== LW'(DEPTH)) begin
            errors++;
            $display("FAIL full_level: got %0d expected %0d", level, DEPTH);
        end
        bload = 1'b1;
        tick();
        asend = '0;
        drain();
    endtask

    task automatic test_simultaneous();
        bload = 1'b0;
        asend = 4'b0010;
        for (int i = 0; i < 2; i++) begin
            adata[DW +: DW] = DW'(8'h60 + i);
            tick();
        end
        adata[DW +: DW] = 8'h62;
        bload = 1'b1;
        tick();
        checks++;
        if (level !== LW'(2)) begin
            errors++;
            $display("FAIL simul_level: got %0d expected 2", level);
        end
        drain();
    endtask

    task automatic test_mid_reset();
        bload = 1'b0;
        asend = 4'b1000;
        for (int i = 0; i < 3; i++) begin
            adata[3*DW +: DW] = DW'(8'h70 + i);
            tick();
        end
        asend  = '0;
        arst_n = 1'b0;
        tick();
        arst_n = 1'b1;
        checks++;
        if (level !== '0 || bvalid !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset: got level %0d v%b expected 0 0", level, bvalid);
        end
        asend = 4'b1000;
        adata[3*DW +: DW] = 8'h3C;
        tick();
        asend = '0;
        got_ch.delete();
        drain();
        checks++;
        if (got_ch.size() != 1) begin
            errors++;
            $display("FAIL mid_reset_count: got %0d expected 1", got_ch.size());
        end
    endtask

    initial begin
        arst_n = 1'b0;
        asend  = '0;
        adata  = '0;
        bload  = 1'b0;
        @(posedge aclk);
        #1;
        test_reset();
        test_single();
        test_round_robin();
        test_full();
        test_simultaneous();
        test_mid_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
